key_debounce_multi: RTL and testbench

KEY_DEBOUNCE_MULTI -- requirements
Module: key_debounce_multi

---
 rtl/key_pkg.sv | 19 +
 rtl/key_chan.sv | 158 +++++++++++++++
 rtl/key_debounce_multi.sv | 75 +++++++
 tb/tb_key_debounce_multi.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared definitions for the multi-key debouncer.
//   key_state_e : per-channel FSM states (RELEASED, PRESSED, LONG_HELD)
//   cnt_width() : bit width needed to hold 0..value (never less than 1 bit)
package key_pkg;

    typedef enum logic [1:0] {
        RELEASED  = 2'd0,
        PRESSED   = 2'd1,
        LONG_HELD = 2'd2
    } key_state_e;

    // $clog2(value+1), clamped to 1 so a zero-valued parameter still yields a legal vector.
    function automatic int unsigned cnt_width(input int unsigned value);
        int unsigned w;
        w = $clog2(value + 1);
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/key_chan.sv
// One key channel: 2-flop synchroniser, polarity normalisation, tick-qualified
// debounce counter and RELEASED/PRESSED/LONG_HELD FSM with hold and repeat counters.
// Ports:
//   clk, rst_n   : clock, async active-low reset
//   tick_i       : one-cycle sample strobe from the shared divider
//   key_i        : raw key pin
//   state_o      : debounced level, 1 = pressed
//   press_o      : one-cycle strobe on accepted press
//   release_o    : one-cycle strobe on accepted release
//   long_o       : one-cycle strobe when the hold reaches LONG_TICKS
//   repeat_o     : one-cycle strobe every REPEAT_TICKS while in LONG_HELD
module key_chan
    import key_pkg::*;
#(
    parameter int unsigned STABLE_CNT   = 3,
    parameter int unsigned LONG_TICKS   = 50,
    parameter int unsigned REPEAT_TICKS = 10,
    parameter bit          ACTIVE_LOW   = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick_i,
    input  logic key_i,
    output logic state_o,
    output logic press_o,
    output logic release_o,
    output logic long_o,
    output logic repeat_o
);

    localparam int unsigned DW = cnt_width(STABLE_CNT);
    localparam int unsigned HW = cnt_width(LONG_TICKS);
    localparam int unsigned RW = cnt_width(REPEAT_TICKS);

    localparam logic [DW-1:0] DiffLast = DW'(STABLE_CNT - 1);
    localparam logic [HW-1:0] HoldMax  = HW'(LONG_TICKS);
    localparam logic [HW-1:0] HoldLast = HW'(LONG_TICKS - 1);
    localparam logic [RW-1:0] RepLast  = RW'((REPEAT_TICKS == 0) ? 0 : REPEAT_TICKS - 1);
    // Released pin level, so reset never looks like a press.
    localparam logic          IdleLevel = ACTIVE_LOW;

    logic            sync1_q, sync2_q;
    logic [DW-1:0]   diff_q, diff_d;
    key_state_e      fsm_q, fsm_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [RW-1:0]   rep_q, rep_d;
    logic            press_q, press_d;
    logic            release_q, release_d;
    logic            long_q, long_d;
    logic            repeat_q, repeat_d;

    logic            sample;
    logic            level;
    logic            accept;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= IdleLevel;
            sync2_q   <= IdleLevel;
            diff_q    <= '0;
            fsm_q     <= RELEASED;
            hold_q    <= '0;
            rep_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
        end else begin
            sync1_q   <= key_i;
            sync2_q   <= sync1_q;
            diff_q    <= diff_d;
            fsm_q     <= fsm_d;
            hold_q    <= hold_d;
            rep_q     <= rep_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            repeat_q  <= repeat_d;
        end
    end

    // Debounce: a new level is accepted on the STABLE_CNT-th consecutive differing tick.
    always_comb begin
        sample = sync2_q ^ IdleLevel;
        level  = (fsm_q != RELEASED);
        diff_d = diff_q;
        accept = 1'b0;
        if (tick_i) begin
            if (sample != level) begin
                if (diff_q == DiffLast) begin
                    accept = 1'b1;
                    diff_d = '0;
                end else begin
                    diff_d = diff_q + 1'b1;
                end
            end else begin
                diff_d = '0;
            end
        end
    end

    // Next state; an accepted release takes priority over a same-tick long/repeat.
    always_comb begin
        fsm_d     = fsm_q;
        hold_d    = hold_q;
        rep_d     = rep_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;
        if (accept && level) begin
            fsm_d     = RELEASED;
            release_d = 1'b1;
            hold_d    = '0;
            rep_d     = '0;
        end else if (accept) begin
            fsm_d   = PRESSED;
            press_d = 1'b1;
            hold_d  = '0;
            rep_d   = '0;
        end else if (tick_i) begin
            case (fsm_q)
                PRESSED: begin
                    if (hold_q != HoldMax) begin
                        hold_d = hold_q + 1'b1;
                        if (hold_q == HoldLast) begin
                            fsm_d  = LONG_HELD;
                            long_d = 1'b1;
                            rep_d  = '0;
                        end
                    end
                end
                LONG_HELD: begin
                    if (REPEAT_TICKS != 0) begin
                        if (rep_q == RepLast) begin
                            rep_d    = '0;
                            repeat_d = 1'b1;
                        end else begin
                            rep_d = rep_q + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs
    always_comb begin
        state_o   = (fsm_q != RELEASED);
        press_o   = press_q;
        release_o = release_q;
        long_o    = long_q;
        repeat_o  = repeat_q;
    end

endmodule

// File: rtl/key_debounce_multi.sv
// Multi-channel key debouncer with long-press and auto-repeat events.
// A single shared divider produces the sample tick; each key is handled by key_chan.
// Ports:
//   clk, rst_n     : clock, async active-low reset
//   key_in         : raw key pins (pressed = low when ACTIVE_LOW)
//   key_state      : debounced levels, 1 = pressed
//   press_pulse    : one-cycle strobes on accepted press
//   release_pulse  : one-cycle strobes on accepted release
//   long_pulse     : one-cycle strobes when a hold reaches LONG_TICKS
//   repeat_pulse   : one-cycle strobes every REPEAT_TICKS after long-press
//   led_out        : LED drive, low while the key is pressed
module key_debounce_multi
    import key_pkg::*;
#(
    parameter int unsigned N_KEYS       = 4,
    parameter int unsigned SCAN_DIV     = 1_000_000,
    parameter int unsigned STABLE_CNT   = 3,
    parameter int unsigned LONG_TICKS   = 50,
    parameter int unsigned REPEAT_TICKS = 10,
    parameter bit          ACTIVE_LOW   = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] key_in,
    output logic [N_KEYS-1:0] key_state,
    output logic [N_KEYS-1:0] press_pulse,
    output logic [N_KEYS-1:0] release_pulse,
    output logic [N_KEYS-1:0] long_pulse,
    output logic [N_KEYS-1:0] repeat_pulse,
    output logic [N_KEYS-1:0] led_out
);

    localparam int unsigned     DivW    = cnt_width(SCAN_DIV);
    localparam logic [DivW-1:0] DivLast = DivW'(SCAN_DIV - 1);

    logic [DivW-1:0] div_q, div_d;
    logic            tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    always_comb begin
        tick  = (div_q == DivLast);
        div_d = tick ? '0 : div_q + 1'b1;
    end

    for (genvar i = 0; i < N_KEYS; i++) begin : g_chan
        key_chan #(
            .STABLE_CNT  (STABLE_CNT),
            .LONG_TICKS  (LONG_TICKS),
            .REPEAT_TICKS(REPEAT_TICKS),
            .ACTIVE_LOW  (ACTIVE_LOW)
        ) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .tick_i   (tick),
            .key_i    (key_in[i]),
            .state_o  (key_state[i]),
            .press_o  (press_pulse[i]),
            .release_o(release_pulse[i]),
            .long_o   (long_pulse[i]),
            .repeat_o (repeat_pulse[i])
        );
    end

    always_comb begin
        led_out = ~key_state;
    end

endmodule

// File: tb/tb_key_debounce_multi.sv
module tb_key_debounce_multi;

    localparam int PRESS   = 0;
    localparam int RELEASE = 1;
    localparam int LONG    = 2;
    localparam int REPEAT  = 3;
    // Accepted-edge latency from pin change: 2 sync + up to one tick period + 2 more ticks.
    localparam int LAT_LO  = 22;
    localparam int LAT_HI  = 33;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] key_in = 4'hF;
    logic [3:0] key_state, press_pulse, release_pulse, long_pulse, repeat_pulse, led_out;

    logic       key_b = 1'b1;
    logic       state_b, press_b, release_b, long_b, repeat_b, led_b;

    key_debounce_multi #(
        .N_KEYS(4), .SCAN_DIV(10), .STABLE_CNT(3), .LONG_TICKS(20), .REPEAT_TICKS(5),
        .ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .key_in(key_in), .key_state(key_state),
        .press_pulse(press_pulse), .release_pulse(release_pulse), .long_pulse(long_pulse),
        .repeat_pulse(repeat_pulse), .led_out(led_out)
    );

    key_debounce_multi #(
        .N_KEYS(1), .SCAN_DIV(10), .STABLE_CNT(3), .LONG_TICKS(20), .REPEAT_TICKS(0),
        .ACTIVE_LOW(1'b1)
    ) dut_norep (
        .clk(clk), .rst_n(rst_n), .key_in(key_b), .key_state(state_b),
        .press_pulse(press_b), .release_pulse(release_b), .long_pulse(long_b),
        .repeat_pulse(repeat_b), .led_out(led_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;
    int last_evt = 0;

    typedef struct {
        int         kind;
        logic [3:0] mask;
        int         base;   // absolute cycle, or -1 = time of previous observed event
        int         lo;
        int         hi;
    } exp_t;

    exp_t exp_q[$];

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic check_win(input string name, input int act, input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0d want %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
        end
    endtask

    task automatic expect_ev(input int kind, input logic [3:0] mask, input int base,
                             input int lo, input int hi);
        exp_t e;
        e.kind = kind;
        e.mask = mask;
        e.base = base;
        e.lo   = lo;
        e.hi   = hi;
        exp_q.push_back(e);
    endtask

    task automatic drain(input string name, input int max_cycles);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        check(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    // Monitor: pops the scoreboard whenever any event strobe is seen.
    initial begin
        logic [3:0] obs [4];
        forever begin
            @(negedge clk);
            if (rst_n) begin
                obs[PRESS]   = press_pulse;
                obs[RELEASE] = release_pulse;
                obs[LONG]    = long_pulse;
                obs[REPEAT]  = repeat_pulse;
                for (int k = 0; k < 4; k++) begin
                    if (obs[k] != 4'b0) begin
                        if (exp_q.size() == 0) begin
                            check($sformatf("unexpected_event_kind%0d", k), int'(obs[k]), 0);
                        end else begin
                            exp_t e;
                            int   ref_cyc;
                            e = exp_q.pop_front();
                            ref_cyc = (e.base < 0) ? last_evt : e.base;
                            check("event_kind", k, e.kind);
                            check("event_mask", int'(obs[k]), int'(e.mask));
                            check_win("event_time", cyc - ref_cyc, e.lo, e.hi);
                        end
                        last_evt = cyc;
                    end
                end
            end
        end
    end

    initial begin
        int n_press, n_long, n_rep;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_key_state", int'(key_state), 0);
        check("rst_led_out", int'(led_out), 15);
        check("rst_pulses", int'(press_pulse | release_pulse | long_pulse | repeat_pulse), 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Key 0: short press and release
        key_in[0] = 1'b0;
        expect_ev(PRESS, 4'b0001, cyc, LAT_LO, LAT_HI);
        drain("k0_press", 60);
        repeat (50) @(negedge clk);
        check("k0_key_state", int'(key_state), 1);
        check("k0_led_out", int'(led_out), 14);
        key_in[0] = 1'b1;
        expect_ev(RELEASE, 4'b0001, cyc, LAT_LO, LAT_HI);
        drain("k0_release", 60);
        check("k0_released_state", int'(key_state), 0);

        // Key 1: glitch lasting two ticks
        key_in[1] = 1'b0;
        repeat (20) @(negedge clk);
        key_in[1] = 1'b1;
        repeat (60) @(negedge clk);
        check("k1_glitch_state", int'(key_state), 0);

        // Key 2: long press with two repeats, then release
        key_in[2] = 1'b0;
        expect_ev(PRESS, 4'b0100, cyc, LAT_LO, LAT_HI);
        expect_ev(LONG, 4'b0100, -1, 200, 200);
        expect_ev(REPEAT, 4'b0100, -1, 50, 50);
        expect_ev(REPEAT, 4'b0100, -1, 50, 50);
        drain("k2_long_repeat", 400);
        key_in[2] = 1'b1;
        expect_ev(RELEASE, 4'b0100, cyc, LAT_LO, LAT_HI);
        drain("k2_release", 60);
        repeat (80) @(negedge clk);
        check("k2_released_state", int'(key_state), 0);

        // Keys 0 and 3 together
        key_in[0] = 1'b0;
        key_in[3] = 1'b0;
        expect_ev(PRESS, 4'b1001, cyc, LAT_LO, LAT_HI);
        drain("k03_press", 60);
        check("k03_key_state", int'(key_state), 9);
        check("k03_led_out", int'(led_out), 6);
        key_in[0] = 1'b1;
        key_in[3] = 1'b1;
        expect_ev(RELEASE, 4'b1001, cyc, LAT_LO, LAT_HI);
        drain("k03_release", 60);

        // Key 2: reset while in LONG_HELD, key kept low
        key_in[2] = 1'b0;
        expect_ev(PRESS, 4'b0100, cyc, LAT_LO, LAT_HI);
        expect_ev(LONG, 4'b0100, -1, 200, 200);
        drain("k2_pre_reset", 300);
        rst_n = 1'b0;
        #1;
        check("midrst_key_state", int'(key_state), 0);
        check("midrst_led_out", int'(led_out), 15);
        check("midrst_pulses", int'(press_pulse | release_pulse | long_pulse | repeat_pulse), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        expect_ev(PRESS, 4'b0100, cyc, LAT_LO, LAT_HI);
        expect_ev(LONG, 4'b0100, -1, 200, 200);
        drain("k2_post_reset", 300);
        key_in[2] = 1'b1;
        expect_ev(RELEASE, 4'b0100, cyc, LAT_LO, LAT_HI);
        drain("k2_post_reset_release", 60);

        // Repeat-disabled build: 600-cycle hold
        n_press = 0;
        n_long  = 0;
        n_rep   = 0;
        key_b = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            n_press += int'(press_b);
            n_long  += int'(long_b);
            n_rep   += int'(repeat_b);
        end
        check("norep_press_count", n_press, 1);
        check("norep_long_count", n_long, 1);
        check("norep_repeat_count", n_rep, 0);
        check("norep_state", int'(state_b), 1);
        check("norep_led", int'(led_b), 0);
        key_b = 1'b1;
        n_rep = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            n_rep += int'(release_b);
        end
        check("norep_release_count", n_rep, 1);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
